// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: sequential ALU with registered result, iterative MULTU/DIVU into HI/LO
// Ports: clk, reset (async, active-high), start/op/a/b/shamt request inputs;
//        busy while iterating, done pulse with result/zero, hi/lo registers, div_by_zero flag.
// Build option: define ALU_SEQ_DIV_EN to compile in the restoring divider (DIVU otherwise unused).
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_NOR = 4'b0010, OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100, OP_LUI = 4'b0101, OP_SLL = 4'b0110, OP_SRL = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000, OP_DIVU = 4'b1001, OP_MFHI = 4'b1010, OP_MFLO = 4'b1011;
  localparam logic [3:0] OP_SRA = 4'b1100;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc, q, m, acc_n, q_n, alu_r;
  logic [WIDTH:0] sum;
  logic [SHW-1:0] cnt;
  logic accept, last, mul_go, div_go, div0;
  assign accept = start && (state == IDLE || state == DONE);
  assign last = cnt == SHW'(WIDTH - 1);
  assign busy = state == MUL || state == DIV;
  assign done = state == DONE;
  assign mul_go = op == OP_MULTU;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0] sh, diff;
  assign div_go = op == OP_DIVU && b != '0;
  assign div0 = op == OP_DIVU && b == '0;
`else
  assign div_go = 1'b0;
  assign div0 = 1'b0;
`endif
  always_comb begin
    alu_r = '0;
    case (op)
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_NOR:  alu_r = ~(a | b);
      OP_ADD:  alu_r = a + b;
      OP_SUB:  alu_r = a - b;
      OP_LUI:  alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_r = b << shamt;
      OP_SRL:  alu_r = b >> shamt;
      OP_SRA:  alu_r = $signed(b) >>> shamt;
      OP_DIVU: alu_r = div0 ? '1 : '0;
      OP_MFHI: alu_r = hi;
      OP_MFLO: alu_r = lo;
      default: alu_r = '0;
    endcase
  end
  // acc:q is the running {product} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    acc_n = sum[WIDTH:1];
    q_n = {sum[0], q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    sh = {acc, q[WIDTH-1]};
    diff = sh - {1'b0, m};
    if (state == DIV) begin
      acc_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      q_n = {q[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end
  always_comb begin
    state_n = state;
    state_n = busy ? (last ? DONE : state) : !start ? IDLE : mul_go ? MUL : div_go ? DIV : DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      result <= '0;
      zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        div_by_zero <= div0;
        cnt <= '0;
        acc <= '0;
        q <= mul_go ? b : a;
        m <= mul_go ? a : b;
        if (!mul_go && !div_go) begin
          result <= alu_r;
          zero <= alu_r == '0;
        end
        if (div0) begin
          hi <= a;
          lo <= '1;
        end
      end else if (busy) begin
        cnt <= cnt + SHW'(1);
        acc <= acc_n;
        q <= q_n;
        if (last) begin
          hi <= acc_n;
          lo <= q_n;
          result <= q_n;
          zero <= q_n == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: directed self-checking bench for alu_seq_muldiv (WIDTH=32)
module tb_alu_seq_muldiv;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] shamt = '0;
  logic busy, done, zero, div_by_zero;
  logic [31:0] result, hi, lo;
  int tests = 0, failed = 0;
  int n, bc, dc;
  logic [31:0] exp_hi, exp_lo;
  alu_seq_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .busy(busy), .done(done), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    shamt = s;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (!done && cycles < 200) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask
  initial begin
    #1;
    check("reset_flags", {60'd0, busy, done, zero, div_by_zero}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(4'b0011, 32'd5, 32'd7, 5'd0);
    check("add_done", {63'd0, done}, 64'd1);
    check("add_res", {31'd0, zero, result}, {31'd0, 1'b0, 32'd12});
    @(negedge clk);
    check("hold", {31'd0, done, result}, {31'd0, 1'b0, 32'd12});
    issue(4'b0100, 32'd9, 32'd9, 5'd0);
    check("sub_zero", {31'd0, zero, result}, {31'd0, 1'b1, 32'd0});
    issue(4'b0101, 32'd0, 32'h0000_1234, 5'd0);
    check("lui", {32'd0, result}, {32'd0, 32'h1234_0000});
    issue(4'b1100, 32'd0, 32'h8000_0000, 5'd4);
    check("sra", {32'd0, result}, {32'd0, 32'hF800_0000});
    issue(4'b0111, 32'd0, 32'h8000_0000, 5'd4);
    check("srl", {32'd0, result}, {32'd0, 32'h0800_0000});
    issue(4'b0110, 32'd0, 32'h0000_0001, 5'd31);
    check("sll", {32'd0, result}, {32'd0, 32'h8000_0000});
    issue(4'b0010, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
    check("nor", {32'd0, result}, {32'd0, 32'hF0F0_FF0F});
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd0);
    check("add_wrap", {31'd0, zero, result}, {31'd0, 1'b1, 32'd0});
    issue(4'b1101, 32'd3, 32'd4, 5'd0);
    check("unused_op", {31'd0, zero, result}, {31'd0, 1'b1, 32'd0});
    issue(4'b1000, 32'hFFFF_FFFF, 32'd2, 5'd0);
    check("mul_busy0", {62'd0, busy, done}, 64'd2);
    wait_done(n, bc);
    check("mul_latency", 64'(n), 64'd32);
    check("mul_busy_cycles", 64'(bc), 64'd32);
    check("mul_hilo", {hi, lo}, {32'h1, 32'hFFFF_FFFE});
    check("mul_res", {31'd0, busy, result}, {31'd0, 1'b0, 32'hFFFF_FFFE});
    issue(4'b1010, 32'd0, 32'd0, 5'd0);
    check("mfhi_b2b", {31'd0, done, result}, {31'd0, 1'b1, 32'h1});
    issue(4'b1011, 32'd0, 32'd0, 5'd0);
    check("mflo", {32'd0, result}, {32'd0, 32'hFFFF_FFFE});
`ifdef ALU_SEQ_DIV_EN
    issue(4'b1001, 32'd100, 32'd7, 5'd0);
    wait_done(n, bc);
    check("div_latency", 64'(n), 64'd32);
    check("div_hilo", {hi, lo}, {32'd2, 32'd14});
    check("div_res", {31'd0, div_by_zero, result}, {31'd0, 1'b0, 32'd14});
    issue(4'b1001, 32'd5, 32'd0, 5'd0);
    check("div0_done", {62'd0, done, div_by_zero}, 64'd3);
    check("div0_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    check("div0_res", {32'd0, result}, {32'd0, 32'hFFFF_FFFF});
    issue(4'b0000, 32'hFF00, 32'h0FF0, 5'd0);
    check("dbz_clear", {31'd0, div_by_zero, result}, {31'd0, 1'b0, 32'h0F00});
    exp_hi = 32'd5;
    exp_lo = 32'hFFFF_FFFF;
`else
    issue(4'b1001, 32'd100, 32'd7, 5'd0);
    check("divoff_done", {61'd0, done, zero, div_by_zero}, 64'd6);
    check("divoff_res", {32'd0, result}, 64'd0);
    check("divoff_hilo", {hi, lo}, {32'h1, 32'hFFFF_FFFE});
    exp_hi = 32'h1;
    exp_lo = 32'hFFFF_FFFE;
`endif
    issue(4'b1000, 32'd3, 32'd5, 5'd0);
    for (int i = 1; i < 10; i++) @(negedge clk);
    issue(4'b0011, 32'd100, 32'd100, 5'd0);
    check("ignored_start", {62'd0, busy, done}, 64'd2);
    check("no_partial_hilo", {hi, lo}, {exp_hi, exp_lo});
    wait_done(n, bc);
    check("mul_unaffected", {31'd0, done, hi, lo}, {31'd0, 1'b1, 32'd0, 32'd15});
    check("mul_res2", {32'd0, result}, {32'd0, 32'd15});
    @(negedge clk);
    issue(4'b1000, 32'd7, 32'd9, 5'd0);
    for (int i = 1; i < 20; i++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_flags", {60'd0, busy, done, zero, div_by_zero}, 64'd0);
    check("abort_regs", {result, hi ^ lo}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    check("abort_no_done", 64'(dc), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
